// File: rtl/program_loader.sv
// program_loader: writes encoded instruction words {op, operand} into program
// memory at consecutive addresses from 0 and holds the processor in reset
// until the load finishes. Optional running XOR checksum output enabled by
// defining PROGRAM_CHECKSUM_EN.
module program_loader #(
    parameter  int OP_W   = 3,
    parameter  int ADDR_W = 5,
    localparam int WORD_W = OP_W + ADDR_W
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_operand,
    input  logic              in_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_we,
    output logic              cpu_n_reset,
    output logic              done,
    output logic              error,
    output logic              trunc,
`ifdef PROGRAM_CHECKSUM_EN
    output logic [WORD_W-1:0] checksum,
`endif
    output logic [ADDR_W:0]   count
);

    // Opcode codes shared with the processor decoder; 6 and 7 are unused.
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(5);

    typedef enum logic [1:0] {LOADING, WRITE, DONE, ERROR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] address;
    logic              last_q;
    logic              accept;
    logic              op_ok;
    logic              addr_max;

    assign accept   = in_valid & in_ready;
    assign addr_max = (address == {ADDR_W{1'b1}});

    // Classify the incoming opcode against the six codes the decoder knows
    always_comb begin
        case (in_op)
            OP_STORE, OP_LOAD, OP_BNE, OP_ADD, OP_SUB, OP_ADDI: op_ok = 1'b1;
            default:                                            op_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) state <= LOADING;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            LOADING: if (accept) state_nxt = op_ok ? WRITE : ERROR;
            WRITE:   state_nxt = (last_q || addr_max) ? DONE : LOADING;
            DONE:    if (start) state_nxt = LOADING;
            ERROR:   if (start) state_nxt = LOADING;
            default: state_nxt = LOADING;
        endcase
    end

    // Combinational outputs: ready is a pure state decode, independent of in_valid
    always_comb begin
        in_ready = (state == LOADING);
    end

    // Registered datapath and status outputs; the write strobe is set on the
    // accepting edge so address/data/we are all stable for the WRITE cycle
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            address     <= '0;
            count       <= '0;
            last_q      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            cpu_n_reset <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            trunc       <= 1'b0;
`ifdef PROGRAM_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                LOADING: begin
                    if (accept) begin
                        if (op_ok) begin
                            mem_we   <= 1'b1;
                            mem_addr <= address;
                            mem_data <= {in_op, in_operand};
                            last_q   <= in_last;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // Address wraps after the top word, but DONE blocks reuse
                    address <= address + 1'b1;
                    count   <= count + 1'b1;
`ifdef PROGRAM_CHECKSUM_EN
                    checksum <= checksum ^ mem_data;
`endif
                    if (last_q || addr_max) begin
                        done        <= 1'b1;
                        cpu_n_reset <= 1'b1;
                        trunc       <= ~last_q;
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        address     <= '0;
                        count       <= '0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        trunc       <= 1'b0;
                        cpu_n_reset <= 1'b0;
`ifdef PROGRAM_CHECKSUM_EN
                        checksum    <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader. A queue-based model
// decides for each program which words are written, where, and how the load
// ends (done / error / truncated), and the expected checksum.
module tb_program_loader;

    localparam int OP_W   = 3;
    localparam int ADDR_W = 5;
    localparam int WORD_W = 8;
    localparam int DEPTH  = 32;

    localparam logic [2:0] OP_STORE = 3'd0, OP_LOAD = 3'd1, OP_BNE = 3'd2,
                           OP_ADD = 3'd3, OP_SUB = 3'd4, OP_ADDI = 3'd5;

    typedef struct {
        logic [2:0] op;
        logic [4:0] opd;
        logic       last;
    } fld_t;

    logic              clock = 1'b0;
    logic              n_reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   in_op = '0;
    logic [ADDR_W-1:0] in_operand = '0;
    logic              in_last = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;
    logic              mem_we;
    logic              cpu_n_reset;
    logic              done;
    logic              error;
    logic              trunc;
    logic [ADDR_W:0]   count;
`ifdef PROGRAM_CHECKSUM_EN
    logic [WORD_W-1:0] checksum;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    fld_t prog[$];

    program_loader dut (
        .clock(clock), .n_reset(n_reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_operand(in_operand), .in_last(in_last),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .cpu_n_reset(cpu_n_reset), .done(done), .error(error), .trunc(trunc),
`ifdef PROGRAM_CHECKSUM_EN
        .checksum(checksum),
`endif
        .count(count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit op_valid(input logic [2:0] op);
        return op inside {OP_STORE, OP_LOAD, OP_BNE, OP_ADD, OP_SUB, OP_ADDI};
    endfunction

    // Present one field set; returns at the negedge following the accepting edge
    task automatic send(input fld_t f, input int gap_max, output bit ok);
        int waited = 0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clock);
        in_valid = 1'b1; in_op = f.op; in_operand = f.opd; in_last = f.last;
        ok = 1'b0;
        while (!ok && waited < 20) begin
            #1;
            if (in_ready) ok = 1'b1;
            @(negedge clock);
            waited++;
        end
        in_valid = 1'b0;
        in_op = 3'($urandom); in_operand = 5'($urandom); in_last = 1'($urandom);
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    // Drive the queued program and check every write plus the final status
    task automatic run_prog(input int gap_max);
        int n_wr = 0;
        int last_cyc = 0;
        bit stop = 0, exp_err = 0, exp_trunc = 0, ok;
        logic [7:0] csum = '0;
        for (int i = 0; i < prog.size() && !stop; i++) begin
            send(prog[i], gap_max, ok);
            if (!ok) return;
            if (!op_valid(prog[i].op)) begin
                exp_err = 1; stop = 1;
            end else begin
                chk("wr_we", mem_we, 1);
                chk("wr_addr", mem_addr, n_wr);
                chk("wr_data", mem_data, {prog[i].op, prog[i].opd});
                chk("wr_count", count, n_wr);
                chk("wr_cpu_rst", cpu_n_reset, 0);
                if (gap_max == 0 && n_wr > 0) chk("wr_spacing", cyc - last_cyc, 2);
                last_cyc = cyc;
                csum ^= {prog[i].op, prog[i].opd};
                n_wr++;
                if (prog[i].last) stop = 1;
                else if (n_wr == DEPTH) begin exp_trunc = 1; stop = 1; end
            end
        end
        if (!exp_err) @(negedge clock);
        chk("end_done", done, !exp_err);
        chk("end_cpu_rst", cpu_n_reset, !exp_err);
        chk("end_error", error, exp_err);
        chk("end_trunc", trunc, exp_trunc);
        chk("end_count", count, n_wr);
        chk("end_ready", in_ready, 0);
        chk("end_we", mem_we, 0);
`ifdef PROGRAM_CHECKSUM_EN
        if (!exp_err) chk("end_checksum", checksum, csum);
`endif
        repeat ($urandom_range(2, 0)) @(negedge clock);
        chk("hold_done", done, !exp_err);
        chk("hold_error", error, exp_err);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_done", done, 0);
        chk("start_error", error, 0);
        chk("start_trunc", trunc, 0);
        chk("start_cpu_rst", cpu_n_reset, 0);
        chk("start_count", count, 0);
        chk("start_ready", in_ready, 1);
`ifdef PROGRAM_CHECKSUM_EN
        chk("start_checksum", checksum, 0);
`endif
    endtask

    task automatic add(input logic [2:0] op, input logic [4:0] opd, input logic last);
        fld_t f;
        f.op = op; f.opd = opd; f.last = last;
        prog.push_back(f);
    endtask

    initial begin
        bit ok;
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_cpu_rst", cpu_n_reset, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_trunc", trunc, 0);
        chk("rst_count", count, 0);
        repeat (2) @(negedge clock);
        n_reset = 1'b1;

        // Basic 3-word program, back to back
        prog = {}; add(OP_ADDI, 5, 0); add(OP_ADD, 3, 0); add(OP_STORE, 7, 1);
        run_prog(0);

        // Invalid opcode as second word
        pulse_start();
        prog = {}; add(OP_LOAD, 1, 0); add(3'd7, 4, 0); add(OP_ADD, 2, 1);
        run_prog(0);

        // Fill memory without in_last
        pulse_start();
        prog = {};
        for (int i = 0; i < DEPTH; i++) add(3'($urandom_range(5, 0)), 5'($urandom), 0);
        run_prog(0);

        // Restart with a single word
        pulse_start();
        prog = {}; add(OP_BNE, 9, 1);
        run_prog(1);

        // Checksum pair
        pulse_start();
        prog = {}; add(OP_LOAD, 1, 0); add(OP_SUB, 2, 1);
        run_prog(0);

        // Reset during the WRITE of word 2
        pulse_start();
        prog = {}; add(OP_ADD, 4, 0); add(OP_SUB, 6, 0);
        send(prog[0], 0, ok);
        send(prog[1], 0, ok);
        chk("pre_rst_we", mem_we, 1);
        n_reset = 1'b0;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_count", count, 0);
        chk("midrst_addr", mem_addr, 0);
        @(negedge clock);
        n_reset = 1'b1;
        @(negedge clock);
        chk("postrst_cpu_rst", cpu_n_reset, 0);
        chk("postrst_ready", in_ready, 1);
        prog = {}; add(OP_ADDI, 17, 1);
        run_prog(0);

        // Randomized programs, including invalid opcodes and truncation
        for (int p = 0; p < 25; p++) begin
            int len;
            pulse_start();
            len = $urandom_range(40, 1);
            prog = {};
            for (int i = 0; i < len; i++) begin
                logic [2:0] op;
                op = ($urandom_range(99, 0) < 4) ? 3'($urandom_range(7, 6))
                                                 : 3'($urandom_range(5, 0));
                add(op, 5'($urandom), (len <= DEPTH) && (i == len - 1));
            end
            run_prog($urandom_range(2, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
